uut_perf_monitor: RTL and testbench
===================================

UUT_PERF_MONITOR -- requirements
Module: uut_perf_monitor

Interface
REQ-001 SHALL have parameter OUTPUT_SIZE, default 64, giving the width of the captured UUT output block.
REQ-002 SHALL have parameter CNT_W, default 32, giving the cycle-counter width.
REQ-003 SHALL have parameter TIMEOUT, default 32'h00FF_FFFF, giving the maximum RUN cycles before abort.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, the same clock that drives the UUT.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port rst_uut, input, 1 bit: UUT reset as driven by the test controller; the high-to-low transition starts a measurement.
REQ-007 SHALL have port end_uut, input, 1 bit: UUT completion flag.
REQ-008 SHALL have port block_o_uut, input, OUTPUT_SIZE bits: UUT output block.
REQ-009 SHALL have port ack_i, input, 1 bit: downstream consumer acknowledge.
REQ-010 SHALL have port result_o, output, OUTPUT_SIZE bits: captured block.
REQ-011 SHALL have port cycles_o, output, CNT_W bits: measured latency in cycles.
REQ-012 SHALL have port valid_o, output, 1 bit: result_o, cycles_o and timeout_o are valid.
REQ-013 SHALL have port timeout_o, output, 1 bit: the measurement was aborted by the TIMEOUT limit.
REQ-014 SHALL have port busy_o, output, 1 bit: high in the ARMED and RUN states.

Function
REQ-015 SHALL implement a four-state FSM: IDLE, ARMED, RUN, REPORT.
REQ-016 In IDLE, rst_uut=1 sampled SHALL move the FSM to ARMED.
REQ-017 In ARMED, the internal counter SHALL be held at 0; rst_uut=0 sampled SHALL move the FSM to RUN.
REQ-018 In RUN, each cycle with end_uut=0 and rst_uut=0 SHALL increment the counter by 1.
REQ-019 cycles_o SHALL report the number of RUN cycles in which end_uut=0 was sampled.
REQ-020 In RUN, end_uut=1 sampled SHALL, on the next edge:
  - load result_o with block_o_uut,
  - load cycles_o with the counter value,
  - set timeout_o=0 and valid_o=1,
  - move the FSM to REPORT.
REQ-021 In RUN, if the counter equals TIMEOUT and end_uut=0, the next edge SHALL:
  - set result_o=0 and cycles_o=TIMEOUT,
  - set timeout_o=1 and valid_o=1,
  - move the FSM to REPORT.
REQ-022 If end_uut=1 and counter==TIMEOUT occur in the same cycle, end_uut SHALL win (normal capture, timeout_o=0).
REQ-023 rst_uut=1 sampled in RUN SHALL abort without a report: the FSM moves to ARMED, the counter clears, and valid_o stays 0. This takes priority over end_uut.
REQ-024 In REPORT, result_o, cycles_o, timeout_o and valid_o SHALL hold stable until ack_i=1 is sampled.
REQ-025 ack_i=1 in REPORT SHALL clear valid_o on the next edge and move the FSM to IDLE; result_o, cycles_o and timeout_o keep their values until the next capture.
REQ-026 ack_i SHALL be ignored in every state except REPORT.
REQ-027 rst_uut activity in REPORT SHALL be ignored.
REQ-028 A new measurement SHALL only begin after a return to IDLE followed by rst_uut=1.
REQ-029 The counter SHALL never wrap: TIMEOUT must be less than 2^CNT_W, and the counter stops at TIMEOUT.
REQ-030 Capture latency SHALL be 1 cycle: end_uut sampled at edge N gives valid_o=1 after edge N+1.
REQ-031 The block SHALL contain no combinational path from any input to any output; all outputs are registered.

Reset
REQ-032 rst=1 sampled SHALL force the FSM to IDLE and clear the counter.
REQ-033 rst=1 sampled SHALL force result_o=0, cycles_o=0, valid_o=0, timeout_o=0 and busy_o=0.
REQ-034 rst SHALL override every other input in the same cycle, including mid-RUN and mid-REPORT.
REQ-035 After rst deasserts, the block SHALL wait in IDLE for a rising rst_uut; rst_uut already high on release SHALL move the FSM to ARMED on the first sampled edge.

Verification
REQ-036 The bench SHALL cover a normal capture:
  - stimulus: rst_uut high 2 cycles, low; end_uut=1 exactly 32 cycles after the first RUN cycle; block_o_uut=64'h3333_DCD3_2132_10D2.
  - response: valid_o=1, cycles_o=32, result_o=64'h3333_DCD3_2132_10D2, timeout_o=0.
REQ-037 The bench SHALL cover timeout:
  - stimulus: TIMEOUT=100; end_uut never asserted.
  - response: valid_o=1, timeout_o=1, cycles_o=100, result_o=0, 101 cycles after RUN entry.
REQ-038 The bench SHALL cover a simultaneous timeout and end:
  - stimulus: TIMEOUT=10; end_uut=1 in the cycle where the counter reaches 10.
  - response: timeout_o=0, cycles_o=10, block captured.
REQ-039 The bench SHALL cover a UUT reset mid-RUN:
  - stimulus: rst_uut=1 at count 5, then low; end_uut at count 7 of the new run.
  - response: no valid_o pulse at the first run, then cycles_o=7.
REQ-040 The bench SHALL cover the ack handshake:
  - stimulus: hold ack_i=0 for 20 cycles in REPORT, toggling block_o_uut and rst_uut.
  - response: outputs stable; ack_i=1 gives valid_o=0 on the next cycle and the FSM in IDLE.
REQ-041 The bench SHALL cover a synchronous reset mid-REPORT:
  - stimulus: rst=1 for 1 cycle with valid_o=1.
  - response: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/uut_perf_monitor.sv
// Measures UUT latency from rst_uut release to end_uut and captures its output block.
// Capture latency is one cycle; a report holds stable until ack_i is sampled.
module uut_perf_monitor #(
  parameter int                OUTPUT_SIZE = 64,
  parameter int                CNT_W       = 32,
  parameter logic [CNT_W-1:0]  TIMEOUT     = CNT_W'(32'h00FF_FFFF)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rst_uut,
  input  logic                   end_uut,
  input  logic [OUTPUT_SIZE-1:0] block_o_uut,
  input  logic                   ack_i,
  output logic [OUTPUT_SIZE-1:0] result_o,
  output logic [CNT_W-1:0]       cycles_o,
  output logic                   valid_o,
  output logic                   timeout_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             capture;
  logic             expire;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_uut) state_d = ARMED;
      end
      ARMED: begin
        if (!rst_uut) state_d = RUN;
      end
      RUN: begin
        // UUT reset beats completion, and completion beats the timeout limit.
        if (rst_uut) begin
          state_d = ARMED;
        end else if (end_uut) begin
          state_d = REPORT;
          capture = 1'b1;
        end else if (cnt_q == TIMEOUT) begin
          state_d = REPORT;
          expire  = 1'b1;
        end
      end
      REPORT: begin
        if (ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      result_o  <= '0;
      cycles_o  <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == ARMED) begin
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        if (rst_uut) begin
          cnt_q <= '0;
        end else if (!end_uut && cnt_q != TIMEOUT) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      if (capture) begin
        result_o  <= block_o_uut;
        cycles_o  <= cnt_q;
        timeout_o <= 1'b0;
        valid_o   <= 1'b1;
      end else if (expire) begin
        result_o  <= '0;
        cycles_o  <= TIMEOUT;
        timeout_o <= 1'b1;
        valid_o   <= 1'b1;
      end else if (state_q == REPORT && ack_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  // Decoded from the state register only, so busy_o has no path from any input.
  assign busy_o = (state_q == ARMED) || (state_q == RUN);

endmodule

// File: tb/tb_uut_perf_monitor.sv
// Directed bench for uut_perf_monitor: one instance with TIMEOUT=100, one with TIMEOUT=10, shared stimulus.
module tb_uut_perf_monitor;
  localparam int OW = 64;
  localparam int CW = 32;
  localparam logic [OW-1:0] BLK_A = 64'h3333_DCD3_2132_10D2;
  localparam logic [OW-1:0] BLK_B = 64'hDEAD_BEEF_0000_0001;
  localparam logic [OW-1:0] BLK_C = 64'h0123_4567_89AB_CDEF;
  localparam logic [OW-1:0] BLK_D = 64'hA5A5_5A5A_F00D_CAFE;
  localparam logic [OW-1:0] BLK_E = 64'h1111_2222_3333_4444;

  logic          clk = 1'b0;
  logic          rst, rst_uut, end_uut, ack_i;
  logic [OW-1:0] block;
  logic [OW-1:0] res_a, res_b;
  logic [CW-1:0] cyc_a, cyc_b;
  logic          val_a, val_b, to_a, to_b, busy_a, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uut_perf_monitor #(.OUTPUT_SIZE(OW), .CNT_W(CW), .TIMEOUT(32'd100)) dut_a (
    .clk(clk), .rst(rst), .rst_uut(rst_uut), .end_uut(end_uut), .block_o_uut(block),
    .ack_i(ack_i), .result_o(res_a), .cycles_o(cyc_a), .valid_o(val_a),
    .timeout_o(to_a), .busy_o(busy_a));

  uut_perf_monitor #(.OUTPUT_SIZE(OW), .CNT_W(CW), .TIMEOUT(32'd10)) dut_b (
    .clk(clk), .rst(rst), .rst_uut(rst_uut), .end_uut(end_uut), .block_o_uut(block),
    .ack_i(ack_i), .result_o(res_b), .cycles_o(cyc_b), .valid_o(val_b),
    .timeout_o(to_b), .busy_o(busy_b));

  typedef struct {
    logic          rst, rst_uut, end_uut, ack;
    logic [OW-1:0] blk;
    logic          valid, timeout, busy;
    logic [CW-1:0] cycles;
    logic [OW-1:0] result;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic r, logic ru, logic e, logic a, logic [OW-1:0] b,
                              logic v, logic t, logic bz, logic [CW-1:0] c, logic [OW-1:0] res);
    vec_t x;
    x.rst = r; x.rst_uut = ru; x.end_uut = e; x.ack = a; x.blk = b;
    x.valid = v; x.timeout = t; x.busy = bz; x.cycles = c; x.result = res;
    return x;
  endfunction

  function automatic logic [98:0] st(logic v, logic t, logic bz, logic [CW-1:0] c, logic [OW-1:0] r);
    return {v, t, bz, c, r};
  endfunction

  function automatic logic [98:0] stat_a();
    return {val_a, to_a, busy_a, cyc_a, res_a};
  endfunction

  function automatic logic [98:0] stat_b();
    return {val_b, to_b, busy_b, cyc_b, res_b};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic tick(input logic r, input logic ru, input logic e, input logic a, input logic [OW-1:0] b);
    rst = r; rst_uut = ru; end_uut = e; ack_i = a; block = b;
    @(posedge clk);
    #1;
  endtask

  task automatic arm_and_run();
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("run_entry_busy", {val_a, busy_a}, 2'b01);
  endtask

  initial begin
    int bad_v;
    int first_a;
    int first_b;

    tbl[0]  = mk(1, 1, 1, 1, BLK_A, 0, 0, 0, 0, '0);
    tbl[1]  = mk(0, 1, 0, 0, '0,    0, 0, 1, 0, '0);
    tbl[2]  = mk(0, 1, 0, 0, '0,    0, 0, 1, 0, '0);
    tbl[3]  = mk(0, 0, 0, 1, '0,    0, 0, 1, 0, '0);
    tbl[4]  = mk(0, 0, 0, 0, '0,    0, 0, 1, 0, '0);
    tbl[5]  = mk(0, 0, 0, 0, '0,    0, 0, 1, 0, '0);
    tbl[6]  = mk(0, 0, 0, 0, '0,    0, 0, 1, 0, '0);
    tbl[7]  = mk(0, 0, 1, 0, BLK_B, 1, 0, 0, 3, BLK_B);
    tbl[8]  = mk(0, 1, 0, 0, BLK_C, 1, 0, 0, 3, BLK_B);
    tbl[9]  = mk(0, 0, 0, 1, BLK_C, 0, 0, 0, 3, BLK_B);
    tbl[10] = mk(0, 0, 0, 0, BLK_C, 0, 0, 0, 3, BLK_B);
    tbl[11] = mk(0, 1, 0, 0, '0,    0, 0, 1, 3, BLK_B);
    tbl[12] = mk(0, 0, 0, 0, '0,    0, 0, 1, 3, BLK_B);
    tbl[13] = mk(0, 0, 1, 0, BLK_C, 1, 0, 0, 0, BLK_C);
    tbl[14] = mk(1, 0, 0, 0, '0,    0, 0, 0, 0, '0);
    tbl[15] = mk(0, 0, 0, 0, '0,    0, 0, 0, 0, '0);

    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].rst, tbl[i].rst_uut, tbl[i].end_uut, tbl[i].ack, tbl[i].blk);
      check($sformatf("vec%0d_a", i), stat_a(),
            st(tbl[i].valid, tbl[i].timeout, tbl[i].busy, tbl[i].cycles, tbl[i].result));
      check($sformatf("vec%0d_b", i), stat_b(),
            st(tbl[i].valid, tbl[i].timeout, tbl[i].busy, tbl[i].cycles, tbl[i].result));
    end

    // Normal capture after 32 counted RUN cycles.
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    arm_and_run();
    bad_v = 0;
    for (int i = 0; i < 32; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, BLK_A);
      if (val_a) bad_v++;
    end
    check("cap32_early_valid", bad_v, 0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, BLK_A);
    check("cap32_report", stat_a(), st(1, 0, 0, 32, BLK_A));
    tick(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("cap32_ack", stat_a(), st(0, 0, 0, 32, BLK_A));

    // Timeout: end_uut never asserted; non-zero block must not be captured.
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    arm_and_run();
    first_a = -1;
    first_b = -1;
    for (int i = 1; i <= 105; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, BLK_A);
      if (val_a && first_a < 0) first_a = i;
      if (val_b && first_b < 0) first_b = i;
    end
    check("tmo100_latency", first_a, 101);
    check("tmo10_latency", first_b, 11);
    check("tmo100_report", stat_a(), st(1, 1, 0, 100, '0));
    check("tmo10_report", stat_b(), st(1, 1, 0, 10, '0));
    tick(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // end_uut in the very cycle the counter reaches TIMEOUT=10.
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    arm_and_run();
    bad_v = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, BLK_D);
      if (val_b) bad_v++;
    end
    check("simul_early_valid", bad_v, 0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, BLK_D);
    check("simul_report_b", stat_b(), st(1, 0, 0, 10, BLK_D));
    check("simul_report_a", stat_a(), st(1, 0, 0, 10, BLK_D));
    tick(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // UUT reset at count 5 aborts silently; the rerun ends at count 7.
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    arm_and_run();
    bad_v = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, BLK_E);
      if (val_a) bad_v++;
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0, BLK_E);
    check("abort_armed", {val_a, busy_a}, 2'b01);
    tick(1'b0, 1'b0, 1'b0, 1'b0, BLK_E);
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, BLK_E);
      if (val_a) bad_v++;
    end
    check("abort_no_valid", bad_v, 0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, BLK_E);
    check("rerun_report", stat_a(), st(1, 0, 0, 7, BLK_E));

    // Report holds through 20 cycles of noise on block_o_uut and rst_uut.
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, i[0], 1'b0, 1'b0, {$urandom, $urandom});
      check($sformatf("hold%0d", i), stat_a(), st(1, 0, 0, 7, BLK_E));
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1, BLK_C);
    check("ack_clear", stat_a(), st(0, 0, 0, 7, BLK_E));
    tick(1'b0, 1'b0, 1'b0, 1'b0, BLK_C);
    check("ack_idle", stat_a(), st(0, 0, 0, 7, BLK_E));
    tick(1'b0, 1'b1, 1'b0, 1'b0, BLK_C);
    check("idle_rearm", stat_a(), st(0, 0, 1, 7, BLK_E));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
